// File: rtl/data_memory_if.sv
// Bus between the datapath controller and the data memory: address,
// strobes, write data and combinational read data.
interface data_memory_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_bus;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  read_en;
    logic                  write_en;
    logic [DATA_WIDTH-1:0] out_bus;

    modport master (
        output in_bus,
        output addr,
        output read_en,
        output write_en,
        input  out_bus
    );

    modport slave (
        input  in_bus,
        input  addr,
        input  read_en,
        input  write_en,
        output out_bus
    );
endinterface

// File: rtl/data_memory.sv
// Single-port word-addressed data memory: synchronous write, combinational
// read gated by read_en, asynchronous clear of the whole array.
module data_memory #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input logic         clk,
    input logic         rst,
    data_memory_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Reset wins over any write presented on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (bus.write_en == 1'b1) begin
            mem[bus.addr] <= bus.in_bus;
        end
    end

    // An unknown read_en falls to the else branch and yields zero.
    always_comb begin
        bus.out_bus = '0;
        if (bus.read_en == 1'b1) begin
            bus.out_bus = mem[bus.addr];
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed plan items plus random
// traffic compared against an array model every cycle.
module tb_data_memory;
    logic clk;
    logic rst;

    data_memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    data_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] model [256];
    int         tests;
    int         fails;
    bit         cmp_en;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
    endtask

    // One clock: present inputs, let the edge happen, then apply its effect.
    task automatic step(input logic [7:0] a, input logic [7:0] d,
                        input logic re, input logic we);
        bus.addr     = a;
        bus.in_bus   = d;
        bus.read_en  = re;
        bus.write_en = we;
        @(posedge clk);
        if (!rst && we) model[a] = d;
        #1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
        bus.addr     = a;
        bus.read_en  = 1'b1;
        bus.write_en = 1'b0;
        #1;
        chk(name, bus.out_bus, exp);
    endtask

    // Every negedge: out_bus must equal the model at the current address.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cycle", bus.out_bus, bus.read_en ? model[bus.addr] : 8'h00);
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        cmp_en = 1'b0;
        rst = 1'b0;
        bus.addr = '0;
        bus.in_bus = '0;
        bus.read_en = 1'b0;
        bus.write_en = 1'b0;
        clear_model();
        #1;
        rst = 1'b1;
        cmp_en = 1'b1;
        step(8'd3, 8'h99, 1'b1, 1'b1);
        step(8'd3, 8'h99, 1'b1, 1'b1);
        rst = 1'b0;

        rd(8'd0,   8'h00, "reset_addr0");
        rd(8'd10,  8'h00, "reset_addr10");
        rd(8'd255, 8'h00, "reset_addr255");
        rd(8'd3,   8'h00, "reset_write_ignored");

        step(8'd10, 8'd34, 1'b0, 1'b1);
        rd(8'd10, 8'd34, "write_read_10");
        bus.read_en = 1'b0;
        #1;
        chk("read_disabled", bus.out_bus, 8'h00);

        step(8'd0,   8'hA5, 1'b0, 1'b1);
        step(8'd255, 8'h5A, 1'b0, 1'b1);
        rd(8'd1,   8'h00, "iso_addr1");
        rd(8'd0,   8'hA5, "iso_addr0");
        rd(8'd255, 8'h5A, "iso_addr255");
        step(8'd10, 8'h00, 1'b0, 1'b0);
        rd(8'd10,  8'd34, "iso_addr10");

        step(8'd20, 8'h11, 1'b0, 1'b1);
        bus.addr = 8'd20;
        bus.in_bus = 8'h22;
        bus.read_en = 1'b1;
        bus.write_en = 1'b1;
        #1;
        chk("rw_before_edge", bus.out_bus, 8'h11);
        @(posedge clk);
        model[20] = 8'h22;
        #1;
        chk("rw_after_edge", bus.out_bus, 8'h22);
        bus.write_en = 1'b0;

        repeat (4) step(8'd10, 8'hFF, 1'b1, 1'b0);
        rd(8'd10, 8'd34, "write_disabled");

        // Asynchronous reset between edges, with a write pending during it.
        bus.addr = 8'd10;
        bus.read_en = 1'b1;
        bus.write_en = 1'b0;
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        chk("async_rst_drop", bus.out_bus, 8'h00);
        bus.in_bus = 8'h77;
        bus.write_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.write_en = 1'b0;
        rd(8'd10, 8'h00, "write_during_rst");
        rd(8'd255, 8'h00, "rst_cleared_255");

        for (int n = 0; n < 3000; n++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            step(a, 8'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                clear_model();
                #1;
                rst = 1'b0;
            end
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Single-port, word-addressed random-access data memory: 256 words of 8 bits by default.
- Serves as the data store of the linear-regression datapath; the controller drives the address and the read/write strobes.
- Writes are synchronous to the clock.
- Reads are combinational and gated by read_en.
- Asynchronous reset clears the whole array.

Parameters:
- DATA_WIDTH, 8, width of each word and of in_bus/out_bus.
- ADDR_WIDTH, 8, width of addr.
- DEPTH, 2**ADDR_WIDTH (256), number of words; every addr value maps to a valid location.

Ports:
- clk  input  1  system clock; all writes on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears every word to 0.
- in_bus  input  DATA_WIDTH  write data.
- addr  input  ADDR_WIDTH  word address, shared by read and write.
- read_en  input  1  read enable, active-high.
- write_en  input  1  write enable, active-high.
- out_bus  output  DATA_WIDTH  read data.

Behaviour:
- Reset:
  - On rst rising, or whenever rst is high, all DEPTH words become 0 immediately, without waiting for a clock.
  - While rst is high, writes are ignored.
  - out_bus during reset: 0 if read_en=1 (memory is zero); 0 if read_en=0.
  - Reset asserted mid-operation aborts any pending write; that location ends at 0.
- Write:
  - At a rising clk edge with rst=0 and write_en=1, mem[addr] <= in_bus.
  - Latency: 1 edge; the new value is visible on out_bus right after that edge, given read_en=1 and the same addr.
  - write_en=0 leaves the memory unchanged.
  - Only the addressed word changes.
- Read:
  - Combinational: out_bus = mem[addr] when read_en=1, else 0.
  - No clock latency; out_bus follows addr changes within the same cycle.
- Simultaneous read_en=1 and write_en=1, same addr:
  - Before the edge, out_bus shows the old content.
  - After the edge, out_bus shows in_bus (write-then-read ordering, no bypass).
- Address range: full ADDR_WIDTH range is valid; no wrap or out-of-range case when DEPTH = 2**ADDR_WIDTH.
- Enable sampling: write only when write_en is exactly 1; read output only when read_en is exactly 1. X or Z on an enable is treated as inactive (no write, out_bus = 0).
- Storage: no initialisation other than reset. Before the first reset, contents are undefined.
- Latching: no handshake or busy signal; a new operation may be issued every cycle.

Test Plan:
- Reset clear: assert rst for 2 cycles, then read_en=1 with addr=0, 10, 255 -> out_bus=0 at each address.
- Write/read: rst=0, addr=10, in_bus=34, write_en=1 for one edge; then write_en=0, read_en=1 -> out_bus=34. With read_en=0 -> out_bus=0.
- Isolation:
  - Write 0xA5 to addr 0 and 0x5A to addr 255.
  - Read addr 1 -> 0; addr 0 -> 0xA5; addr 255 -> 0x5A.
  - Addr 10 still 34.
- Same-cycle read/write:
  - addr=20 holds 0x11; read_en=1, write_en=1, in_bus=0x22.
  - out_bus=0x11 before the edge, 0x22 after.
- Write disabled: write_en=0, in_bus=0xFF, addr=10 across several edges -> out_bus stays 34.
- Async reset mid-run:
  - With addr=10 holding 34 and read_en=1, pulse rst between clock edges.
  - out_bus drops to 0 before the next edge.
  - A write_en=1 edge during rst leaves the location at 0.
